ct_accum_stream: RTL
====================

Name: ct_accum_stream

Overview:
- Streaming ciphertext accumulator that sits directly downstream of the combinational ct_ct_add stage.
- Accepts a packet of ciphertexts (CT_t, N slots each of A and B) over a valid/ready input and adds them element-wise mod QP into a running sum.
- Emits the final sum ciphertext and term count over a valid/ready output.
- Used to sum many encrypted values, for example dot-product reductions, before decryption.

Parameters:
- N, N_SLOTS_L (8), slots per ciphertext polynomial.
- W, W_BITS_L (16), coefficient width in bits.
- QP, 16'd7710, ciphertext modulus; all coefficients lie in [0, QP).
- MAX_TERMS, 16, maximum ciphertexts per packet; the packet auto-closes when this count is reached.
- CW, $clog2(MAX_TERMS+1), width of the term counter.

Ports:
- clk  in  1  single clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_ct and in_last are valid.
- in_ready  out  1  accumulator can accept a term.
- in_ct  in  CT_t  input ciphertext (A[N], B[N], W bits each).
- in_last  in  1  final term of the packet.
- out_valid  out  1  out_ct and out_count are valid.
- out_ready  in  1  consumer accepts the result.
- out_ct  out  CT_t  accumulated ciphertext.
- out_count  out  CW  number of terms summed.

Behaviour:
- Reset (sync, rst=1 at a clk edge) sets:
  - state to S_EMPTY,
  - accumulator all zeros,
  - count 0,
  - out_valid 0.
- Outputs are registered. out_ct and out_count show the accumulator and count registers directly.
- in_ready = (state != S_DONE). A term is accepted on a clock edge where in_valid && in_ready.
- States:
  - S_EMPTY: on accept, load acc = in_ct (no add) and count = 1. Go to S_DONE if in_last or MAX_TERMS==1; otherwise go to S_ACC.
  - S_ACC: on accept, acc[i] = modadd(acc[i], in_ct[i]) for every A and B slot, and count += 1. Go to S_DONE if in_last or count+1 == MAX_TERMS.
  - S_DONE: out_valid=1. On out_ready, clear acc and count and go to S_EMPTY. The next term is accepted one cycle later (no accept/emit overlap).
- Latency: the result is valid on the cycle after the last term is accepted.
- The output holds stable while out_valid && !out_ready.
- modadd(a,b):
  - s = a + b computed at W+1 bits;
  - result = (s >= QP) ? s - QP : s.
  - Inputs are trusted to be < QP; the result is always < QP.
- A term with in_last arriving when count+1 == MAX_TERMS closes the packet once, normally.
- in_valid while in S_DONE is not accepted; the upstream must hold its data.
- rst asserted mid-packet or in S_DONE discards the partial sum with no output. out_valid drops on the next edge.

Optional Feature:
- Macro: CT_ACCUM_RANGE_CHECK_EN.
- When defined:
  - adds port out_err (out, 1), valid with out_valid;
  - out_err is set if any accepted in_ct coefficient is >= QP during the packet;
  - the flag is sticky until the packet is emitted or reset;
  - the arithmetic is unchanged.
- When undefined: the port and the check logic are absent, with no range checking.

Decomposition:
- Shared package / types.svh holds:
  - N_SLOTS_L, W_BITS_L, QP,
  - vec_t, CT_t,
  - the state enum ct_acc_state_t.
- Single sub-module ct_modadd_vec (N, W, QP): combinational slot-wise modular add of two vec_t. Instantiate it twice, once for A and once for B.

Test Plan:
- Two-term packet. CT1 is A=[1429,4717,6311,3279,7215,6215,6931,973], B=[7531,4381,1094,7529,5909,964,5576,4640]. CT2 (in_last=1) is A=[1081,592,951,5762,2873,4,152,3013], B=[1577,3917,6039,6187,2056,6280,1531,7656]. Required response: out_count=2, A=[2510,5309,7262,1331,2378,6219,7083,3986], B=[1398,588,7133,6006,255,7244,7107,4586].
- Three terms (CT1, CT2, CT2 last): out_count=3, A[0]=3591, A[4]=5251, B[0]=2975, B[1]=4505 (with wrap).
- Single term with in_last: output equals the input exactly, out_count=1, one cycle after accept.
- MAX_TERMS=16 with in_last never asserted: 16 copies of CT all-ones gives out_count=16 and every slot=16. in_ready=0 while out_ready is held low for 5 cycles, and the output stays stable.
- Reset mid-packet after 2 terms: no out_valid. A new single-term packet [7709,...] gives an output of 7709 (no residue from the old sum).
- With CT_ACCUM_RANGE_CHECK_EN: a term with A[3]=7710 gives out_err=1. The next clean packet gives out_err=0.

Source files
------------

// File: rtl/ct_accum_stream_pkg.sv
// Shared types and constants for the ciphertext stream accumulator.
package ct_accum_stream_pkg;

    localparam int unsigned N_SLOTS_L = 8;
    localparam int unsigned W_BITS_L  = 16;
    localparam logic [W_BITS_L-1:0] QP = 16'd7710;
    localparam int unsigned MAX_TERMS = 16;
    localparam int unsigned CW        = $clog2(MAX_TERMS + 1);

    typedef logic [N_SLOTS_L-1:0][W_BITS_L-1:0] vec_t;

    typedef struct packed {
        vec_t a;
        vec_t b;
    } CT_t;

    typedef logic [1:0] ct_acc_state_t;

    localparam ct_acc_state_t S_EMPTY = 2'd0;
    localparam ct_acc_state_t S_ACC   = 2'd1;
    localparam ct_acc_state_t S_DONE  = 2'd2;

    // True when any coefficient of the vector lies outside [0, QP).
    function automatic logic vec_out_of_range(input vec_t v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_SLOTS_L); i++) begin
            r = r | (v[i] >= QP);
        end
        return r;
    endfunction

endpackage

// File: rtl/ct_modadd_vec.sv
// Slot-wise modular addition of two coefficient vectors (operands assumed < QP).
module ct_modadd_vec #(
    parameter int unsigned N  = 8,
    parameter int unsigned W  = 16,
    parameter logic [W-1:0] QP = W'(7710)
) (
    input  logic [N-1:0][W-1:0] op_a,
    input  logic [N-1:0][W-1:0] op_b,
    output logic [N-1:0][W-1:0] sum_c
);

    for (genvar i = 0; i < int'(N); i++) begin : g_slot
        logic [W:0] s;
        assign s        = (W+1)'(op_a[i]) + (W+1)'(op_b[i]);
        assign sum_c[i] = (s >= (W+1)'(QP)) ? W'(s - (W+1)'(QP)) : W'(s);
    end

endmodule

// File: rtl/ct_accum_stream.sv
// Streaming accumulator: sums a packet of ciphertexts mod QP and emits the total.
// Optional range checking is enabled with CT_ACCUM_RANGE_CHECK_EN.
module ct_accum_stream
    import ct_accum_stream_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  CT_t           in_ct,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output CT_t           out_ct,
    output logic [CW-1:0] out_count
`ifdef CT_ACCUM_RANGE_CHECK_EN
    ,
    output logic          out_err
`endif
);

    ct_acc_state_t state_q, state_d;
    CT_t           acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    vec_t          sum_a_c, sum_b_c;
    logic          accept_c;

    assign accept_c = in_valid && in_ready_q;

    ct_modadd_vec #(.N(N_SLOTS_L), .W(W_BITS_L), .QP(QP)) u_add_a (
        .op_a  (acc_q.a),
        .op_b  (in_ct.a),
        .sum_c (sum_a_c)
    );

    ct_modadd_vec #(.N(N_SLOTS_L), .W(W_BITS_L), .QP(QP)) u_add_b (
        .op_a  (acc_q.b),
        .op_b  (in_ct.b),
        .sum_c (sum_b_c)
    );

    // Next-state, accumulator and count update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        case (state_q)
            S_EMPTY: begin
                if (accept_c) begin
                    acc_d   = in_ct;
                    count_d = CW'(1);
                    state_d = (in_last || (MAX_TERMS == 1)) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (accept_c) begin
                    acc_d.a = sum_a_c;
                    acc_d.b = sum_b_c;
                    count_d = count_q + CW'(1);
                    if (in_last || (count_q + CW'(1) == CW'(MAX_TERMS))) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ct    = acc_q;
    assign out_count = count_q;

`ifdef CT_ACCUM_RANGE_CHECK_EN
    logic err_q, err_d;
    logic bad_c;

    assign bad_c = vec_out_of_range(in_ct.a) | vec_out_of_range(in_ct.b);

    // Sticky flag across the packet, cleared when the result is taken.
    always_comb begin
        err_d = err_q;
        case (state_q)
            S_EMPTY: if (accept_c) err_d = bad_c;
            S_ACC:   if (accept_c) err_d = err_q | bad_c;
            S_DONE:  if (out_ready) err_d = 1'b0;
            default: err_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_err = err_q;
`endif

endmodule
